// File: rtl/stdp_pkg.sv
// Shared FSM state type and arithmetic helpers for the STDP learning engine.
package stdp_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    // The nearest spike (lowest set history bit) selects the shift.
    function automatic int unsigned stdp_delta(input logic [31:0] hist,
                                               input int unsigned window,
                                               input int unsigned amp);
        int unsigned d;
        d = 0;
        for (int k = 31; k >= 0; k--) begin
            if ((k < int'(window)) && hist[k]) d = amp >> k;
        end
        return d;
    endfunction

    function automatic int unsigned sat_add(input int sum, input int unsigned wmax);
        if (sum < 0) return 0;
        else if (sum > int'(wmax)) return wmax;
        else return $unsigned(sum);
    endfunction

endpackage

// File: rtl/stdp_spike_history.sv
// WINDOW-deep spike history for one channel; reports whether any spike is held
// and the nearest-spike amplitude AMP >> age.
module stdp_spike_history
    import stdp_pkg::*;
#(
    parameter int WINDOW = 4,
    parameter int AMP    = 4,
    parameter int DW     = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          spike_i,
    output logic          any_o,
    output logic [DW-1:0] delta_o
);

    logic [WINDOW-1:0] hist_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) hist_q <= '0;
        else        hist_q <= {hist_q[WINDOW-2:0], spike_i};
    end

    assign any_o   = |hist_q;
    assign delta_o = DW'(stdp_delta(32'(hist_q), WINDOW, AMP));

endmodule

// File: rtl/stdp_learning_engine.sv
// STDP weight engine for one post-synaptic neuron: snapshots spike histories on a
// learning event, then updates one channel weight per clock with saturation.
module stdp_learning_engine
    import stdp_pkg::*;
#(
    parameter int N_PRE    = 16,
    parameter int W_BITS   = 4,
    parameter int WINDOW   = 4,
    parameter int A_PLUS   = 4,
    parameter int A_MINUS  = 2,
    parameter int W_INIT   = 8,
    parameter int OVR_BITS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      learn_en,
    input  logic [N_PRE-1:0]          pre_spike,
    input  logic                      post_spike,
    input  logic                      wr_en,
    input  logic [$clog2(N_PRE)-1:0]  wr_addr,
    input  logic [W_BITS-1:0]         wr_data,
    input  logic [$clog2(N_PRE)-1:0]  rd_addr,
    output logic [W_BITS-1:0]         rd_data,
    output logic [N_PRE*W_BITS-1:0]   weights_flat,
    output logic                      busy,
    output logic                      done,
    output logic [OVR_BITS-1:0]       overrun_cnt
);

    localparam int IW = $clog2(N_PRE);
    localparam int DW = W_BITS + 2;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_PRE - 1);
    localparam int W_MAX = (1 << W_BITS) - 1;

    logic [N_PRE-1:0] pre_any;
    logic [DW-1:0]    pre_dp [N_PRE];
    logic             post_any;
    logic [DW-1:0]    post_dm;

    state_e            state_q;
    logic [IW-1:0]     idx_q;
    logic              post_now_q;
    logic              post_any_q;
    logic [DW-1:0]     post_dm_q;
    logic [N_PRE-1:0]  pre_now_q;
    logic [N_PRE-1:0]  pre_any_q;
    logic [DW-1:0]     pre_dp_q [N_PRE];
    logic              busy_q;
    logic              done_q;
    logic [OVR_BITS-1:0] ovr_q;
    logic [W_BITS-1:0] weight_q [N_PRE];
    logic [W_BITS-1:0] rd_data_q;

    logic                 trigger;
    logic signed [DW-1:0] sum_d;
    logic [W_BITS-1:0]    weight_d;

    for (genvar g = 0; g < N_PRE; g++) begin : g_pre
        stdp_spike_history #(.WINDOW(WINDOW), .AMP(A_PLUS), .DW(DW)) u_pre_hist (
            .clock   (clock),
            .reset   (reset),
            .spike_i (pre_spike[g]),
            .any_o   (pre_any[g]),
            .delta_o (pre_dp[g])
        );
    end

    stdp_spike_history #(.WINDOW(WINDOW), .AMP(A_MINUS), .DW(DW)) u_post_hist (
        .clock   (clock),
        .reset   (reset),
        .spike_i (post_spike),
        .any_o   (post_any),
        .delta_o (post_dm)
    );

    // History excludes the current sample, so a same-cycle pre/post pair adds nothing.
    assign trigger = learn_en & (post_spike | ((|pre_spike) & post_any));

    always_comb begin
        sum_d = $signed({2'b00, weight_q[idx_q]});
        if (post_now_q && pre_any_q[idx_q]) sum_d = sum_d + $signed(pre_dp_q[idx_q]);
        if (pre_now_q[idx_q] && post_any_q) sum_d = sum_d - $signed(post_dm_q);
        weight_d = W_BITS'(sat_add(int'(sum_d), W_MAX));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            post_now_q <= 1'b0;
            post_any_q <= 1'b0;
            post_dm_q  <= '0;
            pre_now_q  <= '0;
            pre_any_q  <= '0;
            for (int i = 0; i < N_PRE; i++) pre_dp_q[i] <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        post_now_q <= post_spike;
                        post_any_q <= post_any;
                        post_dm_q  <= post_dm;
                        pre_now_q  <= pre_spike;
                        pre_any_q  <= pre_any;
                        pre_dp_q   <= pre_dp;
                        idx_q      <= '0;
                        state_q    <= SCAN;
                        busy_q     <= 1'b1;
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (trigger && (state_q != IDLE) && (ovr_q != '1)) ovr_q <= ovr_q + 1'b1;
        end
    end

    // The host write is ordered last so it overrides an engine update to the same channel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PRE; i++) weight_q[i] <= W_BITS'(W_INIT);
            rd_data_q <= '0;
        end else begin
            rd_data_q <= weight_q[rd_addr];
            if (state_q == SCAN) weight_q[idx_q] <= weight_d;
            if (wr_en) weight_q[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < N_PRE; g++) begin : g_flat
        assign weights_flat[g*W_BITS +: W_BITS] = weight_q[g];
    end

    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_stdp_learning_engine.sv
// Directed bench for stdp_learning_engine: LTP, LTD, window limit, saturation,
// overrun, learn_en gating, host-write collision and mid-scan reset.
module tb_stdp_learning_engine;

    logic        clock;
    logic        reset;
    logic        learn_en;
    logic [15:0] pre_spike;
    logic        post_spike;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [3:0]  rd_addr;
    logic [3:0]  rd_data;
    logic [63:0] weights_flat;
    logic        busy;
    logic        done;
    logic [7:0]  overrun_cnt;

    int passed = 0;
    int total  = 0;
    logic [3:0] expW [16];

    stdp_learning_engine dut (
        .clock        (clock),
        .reset        (reset),
        .learn_en     (learn_en),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .weights_flat (weights_flat),
        .busy         (busy),
        .done         (done),
        .overrun_cnt  (overrun_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic le, input logic [15:0] pre, input logic post);
        learn_en   = le;
        pre_spike  = pre;
        post_spike = post;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] packExp();
        logic [63:0] p;
        for (int i = 0; i < 16; i++) p[i*4 +: 4] = expW[i];
        return p;
    endfunction

    function automatic logic [3:0] getW(input int ch);
        return weights_flat[ch*4 +: 4];
    endfunction

    initial begin
        reset = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        applyStimulus(1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) expW[i] = 4'd8;
        #22;

        // Reset state
        checkOutput("reset_weights", weights_flat, packExp());
        checkOutput("reset_rd_data", 64'(rd_data), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_overrun", 64'(overrun_cnt), 64'(0));
        reset = 1'b1;

        // LTP: pre[1] at cycle 0, post at cycle 2 -> weight[1] = 8 + (4>>1)
        applyStimulus(1'b1, 16'h0002, 1'b0); step(1);
        checkOutput("ltp_no_trigger_on_pre", 64'(busy), 64'(0));
        applyStimulus(1'b1, 16'h0000, 1'b0); step(1);
        applyStimulus(1'b1, 16'h0000, 1'b1); step(1);
        checkOutput("ltp_busy_start", 64'(busy), 64'(1));
        checkOutput("ltp_done_low", 64'(done), 64'(0));
        applyStimulus(1'b1, 16'h0000, 1'b0); step(1);
        checkOutput("ltp_w1_before_write", 64'(getW(1)), 64'(8));
        step(1);
        checkOutput("ltp_w1_written", 64'(getW(1)), 64'(10));
        expW[1] = 4'd10;
        step(13);
        checkOutput("ltp_busy_last_scan", 64'(busy), 64'(1));
        checkOutput("ltp_done_not_yet", 64'(done), 64'(0));
        step(1);
        checkOutput("ltp_done_pulse", 64'(done), 64'(1));
        checkOutput("ltp_busy_in_done", 64'(busy), 64'(1));
        step(1);
        checkOutput("ltp_done_cleared", 64'(done), 64'(0));
        checkOutput("ltp_busy_cleared", 64'(busy), 64'(0));
        checkOutput("ltp_weights", weights_flat, packExp());
        rd_addr = 4'd1; step(1);
        checkOutput("ltp_rd_data", 64'(rd_data), 64'(10));

        // LTD: post one cycle before pre[3] -> weight[3] = 8 - (2>>0)
        applyStimulus(1'b0, 16'h0000, 1'b1); step(1);
        checkOutput("ltd_post_gated", 64'(busy), 64'(0));
        applyStimulus(1'b1, 16'h0008, 1'b0); step(1);
        checkOutput("ltd_pre_triggers", 64'(busy), 64'(1));
        applyStimulus(1'b1, 16'h0000, 1'b0); step(17);
        checkOutput("ltd_idle_again", 64'(busy), 64'(0));
        expW[3] = 4'd6;
        checkOutput("ltd_weights", weights_flat, packExp());

        // Pre five cycles after post falls outside the window
        applyStimulus(1'b0, 16'h0000, 1'b1); step(1);
        applyStimulus(1'b1, 16'h0000, 1'b0); step(4);
        applyStimulus(1'b1, 16'h0008, 1'b0); step(1);
        checkOutput("window_no_trigger", 64'(busy), 64'(0));
        applyStimulus(1'b1, 16'h0000, 1'b0); step(1);
        checkOutput("window_weights", weights_flat, packExp());
        step(5);

        // Saturation high: weight[5] = 15, pre[5] then post -> stays 15
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'd15; step(1);
        wr_en = 1'b0;
        expW[5] = 4'd15;
        applyStimulus(1'b1, 16'h0020, 1'b0); step(1);
        checkOutput("sat_hi_pre_only", 64'(busy), 64'(0));
        applyStimulus(1'b1, 16'h0000, 1'b1); step(1);
        checkOutput("sat_hi_busy", 64'(busy), 64'(1));
        applyStimulus(1'b1, 16'h0000, 1'b0); step(17);
        checkOutput("sat_hi_weights", weights_flat, packExp());
        step(5);

        // Saturation low: weight[6] = 1, post then pre[6] -> clamps to 0
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 4'd1; step(1);
        wr_en = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b1); step(1);
        applyStimulus(1'b1, 16'h0040, 1'b0); step(1);
        checkOutput("sat_lo_busy", 64'(busy), 64'(1));
        applyStimulus(1'b1, 16'h0000, 1'b0); step(17);
        expW[6] = 4'd0;
        checkOutput("sat_lo_weights", weights_flat, packExp());
        checkOutput("sat_lo_no_overrun", 64'(overrun_cnt), 64'(0));
        step(5);

        // Overrun: second post five cycles into the scan is dropped
        applyStimulus(1'b1, 16'h0000, 1'b1); step(1);
        checkOutput("ovr_busy", 64'(busy), 64'(1));
        applyStimulus(1'b1, 16'h0000, 1'b0); step(4);
        applyStimulus(1'b1, 16'h0000, 1'b1); step(1);
        checkOutput("ovr_count", 64'(overrun_cnt), 64'(1));
        applyStimulus(1'b1, 16'h0000, 1'b0); step(11);
        checkOutput("ovr_done_on_time", 64'(done), 64'(1));
        step(1);
        checkOutput("ovr_idle", 64'(busy), 64'(0));
        checkOutput("ovr_weights", weights_flat, packExp());

        // learn_en low: spikes shift history but never start a scan
        applyStimulus(1'b0, 16'hFFFF, 1'b1); step(3);
        checkOutput("gate_no_busy", 64'(busy), 64'(0));
        checkOutput("gate_overrun_kept", 64'(overrun_cnt), 64'(1));
        applyStimulus(1'b0, 16'h0000, 1'b0); step(6);
        checkOutput("gate_weights", weights_flat, packExp());
        applyStimulus(1'b1, 16'h0000, 1'b0);

        // Collision: host writes 3 to channel 4 in the cycle the engine writes 12
        applyStimulus(1'b1, 16'h0010, 1'b0); step(1);
        applyStimulus(1'b1, 16'h0000, 1'b1); step(1);
        checkOutput("coll_busy", 64'(busy), 64'(1));
        applyStimulus(1'b1, 16'h0000, 1'b0);
        rd_addr = 4'd4; step(4);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 4'd3; step(1);
        wr_en = 1'b0;
        checkOutput("coll_rd_prewrite", 64'(rd_data), 64'(8));
        checkOutput("coll_host_wins", 64'(getW(4)), 64'(3));
        step(1);
        checkOutput("coll_rd_after", 64'(rd_data), 64'(3));
        step(11);
        expW[4] = 4'd3;
        checkOutput("coll_weights", weights_flat, packExp());
        checkOutput("coll_idle", 64'(busy), 64'(0));

        // Reset at idx 7 aborts the scan and restores every weight
        applyStimulus(1'b1, 16'h0000, 1'b1); step(1);
        applyStimulus(1'b1, 16'h0000, 1'b0); step(7);
        checkOutput("mid_busy", 64'(busy), 64'(1));
        reset = 1'b0; #2;
        for (int i = 0; i < 16; i++) expW[i] = 4'd8;
        checkOutput("mid_reset_weights", weights_flat, packExp());
        checkOutput("mid_reset_busy", 64'(busy), 64'(0));
        checkOutput("mid_reset_overrun", 64'(overrun_cnt), 64'(0));
        checkOutput("mid_reset_rd", 64'(rd_data), 64'(0));
        reset = 1'b1;
        step(2);
        checkOutput("post_reset_idle", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
